seq_multiplier: RTL and testbench

Sequential shift-and-add multiplier: the multiply counterpart to the team's array divider in the arithmetic datapath. It accepts two WIDTH-bit operands on a start pulse and iterates one multiplier bit per clock. It then presents a 2·WIDTH-bit product with a one-cycle done pulse. It gives the datapath a small-area multiply for results that feed the divider stages or are checked against them.

---
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one multiplier bit per clock, 2*WIDTH-bit product.
// Define MUL_SIGNED_EN for two's-complement operands and product (default build is unsigned).

module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // CALC  | one conditional add and shift per edge, busy=1
  // DONE  | product just written to P, done=1 for one cycle
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_CALC = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;

  // One-hot state bits drive the handshake outputs straight from flops.
  assign ready = state[0];
  assign busy  = state[1];
  assign done  = state[2];

  assign acc_next = acc + (mb[0] ? mcand : '0);

`ifdef MUL_SIGNED_EN
  logic sign;

  // |-2^(W-1)| wraps to 2^(W-1), which is still correct when read as unsigned.
  assign a_mag  = A[WIDTH-1] ? -A : A;
  assign b_mag  = B[WIDTH-1] ? -B : B;
  assign result = sign ? -acc_next : acc_next;
`else
  assign a_mag  = A;
  assign b_mag  = B;
  assign result = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      mcand <= '0;
      mb    <= '0;
      count <= '0;
      P     <= '0;
`ifdef MUL_SIGNED_EN
      sign  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CALC;
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            count <= '0;
`ifdef MUL_SIGNED_EN
            sign  <= A[WIDTH-1] ^ B[WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mb    <= mb >> 1;
          count <= count + CW'(1);
          // The final iteration's addition goes straight into P.
          if (count == LAST_CNT) begin
            state <= S_DONE;
            P     <= result;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corners plus random operands vs. an arithmetic model.
// Build with MUL_SIGNED_EN defined to exercise the signed variant.

module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int checks;
  int errors;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product as plain integer arithmetic on the operand values.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (2*W)'(sa * sb);
`else
    return (2*W)'(int'(a) * int'(b));
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation and reports what was observed; callers do the comparing.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] p, output int lat,
                       output int pulse, output int busy_cnt);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    p = P;
    pulse = 0;
    while (done && pulse < 5) begin
      pulse++;
      tick();
    end
    if (n >= 20) lat = -1;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] p;
    int lat, pulse, bc;
    #12;
    checks++;
    if (P !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: P=%h ready=%b busy=%b done=%b, want P=00 ready=1 busy=0 done=0",
               P, ready, busy, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_op(4'd7, 4'd5, p, lat, pulse, bc);
    // Assert reset away from any clock edge; outputs must clear immediately.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (P !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: P=%h ready=%b busy=%b done=%b, want P=00 ready=1 busy=0 done=0",
               P, ready, busy, done);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_corners();
    logic [W-1:0] ca [6];
    logic [W-1:0] cb [6];
    logic [2*W-1:0] p;
    int lat, pulse, bc;
    ca = '{4'd15, 4'd0, 4'd7, 4'd15, 4'd1, 4'd9};
    cb = '{4'd15, 4'd9, 4'd3, 4'd0,  4'd1, 4'd15};
    for (int i = 0; i < 6; i++) begin
      do_op(ca[i], cb[i], p, lat, pulse, bc);
      checks++;
      if (p !== model(ca[i], cb[i])) begin
        errors++;
        $display("FAIL corner_product %0d*%0d: got %h want %h", ca[i], cb[i], p, model(ca[i], cb[i]));
      end
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL corner_latency: done seen %0d edges after accept, want %0d", lat, W);
      end
      checks++;
      if (pulse !== 1) begin
        errors++;
        $display("FAIL corner_done_width: done lasted %0d cycles, want 1", pulse);
      end
      checks++;
      if (bc !== W) begin
        errors++;
        $display("FAIL corner_busy_cycles: busy for %0d cycles, want %0d", bc, W);
      end
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL corner_ready_after: ready=%b, want 1", ready);
      end
    end
  endtask

  task automatic test_start_during_busy();
    int lat;
    int early;
    A = 4'd5;
    B = 4'd6;
    start = 1'b1;
    tick();
    A = 4'd1;
    B = 4'd1;
    lat = 0;
    early = 0;
    while (!done && lat < 20) begin
      if (ready) early++;
      tick();
      lat++;
    end
    checks++;
    if (P !== model(4'd5, 4'd6) || lat !== W) begin
      errors++;
      $display("FAIL busy_first_result: P=%h after %0d edges, want %h after %0d", P, lat, model(4'd5, 4'd6), W);
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL busy_ready_early: ready seen %0d times while busy, want 0", early);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_extra_done: ready=%b done=%b, want ready=1 done=0", ready, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_second_accept: busy=%b, want 1", busy);
    end
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (P !== model(4'd1, 4'd1) || lat !== W) begin
      errors++;
      $display("FAIL busy_second_result: P=%h after %0d edges, want %h after %0d", P, lat, model(4'd1, 4'd1), W);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [2*W-1:0] p;
    int lat, pulse, bc;
    A = 4'd9;
    B = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (P !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: P=%h ready=%b busy=%b done=%b, want P=00 ready=1 busy=0 done=0",
               P, ready, busy, done);
    end
    #2 rst_n = 1'b1;
    tick();
    do_op(4'd2, 4'd3, p, lat, pulse, bc);
    checks++;
    if (p !== model(4'd2, 4'd3) || lat !== W) begin
      errors++;
      $display("FAIL midop_fresh_op: P=%h after %0d edges, want %h after %0d", p, lat, model(4'd2, 4'd3), W);
    end
  endtask

  task automatic test_back_to_back();
    int t, nd, t1, t2, hold_bad;
    logic [2*W-1:0] p1, p2;
    t = 0; nd = 0; t1 = 0; t2 = 0; hold_bad = 0;
    p1 = '0; p2 = '0;
    A = 4'd3;
    B = 4'd4;
    start = 1'b1;
    tick();
    A = 4'd15;
    B = 4'd1;
    while (nd < 2 && t < 40) begin
      if (done) begin
        if (nd == 0) begin t1 = t; p1 = P; end
        else begin t2 = t; p2 = P; end
        nd++;
      end else if (busy && nd == 1 && P !== model(4'd3, 4'd4)) begin
        hold_bad++;
      end
      tick();
      t++;
    end
    start = 1'b0;
    checks++;
    if (nd !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: saw %0d done pulses, want 2", nd);
    end
    checks++;
    if (p1 !== model(4'd3, 4'd4) || p2 !== model(4'd15, 4'd1)) begin
      errors++;
      $display("FAIL b2b_products: got %h,%h want %h,%h", p1, p2, model(4'd3, 4'd4), model(4'd15, 4'd1));
    end
    checks++;
    if (t2 - t1 !== W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, want %0d", t2 - t1, W + 2);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL b2b_p_hold: P changed in %0d busy cycles of second op, want 0", hold_bad);
    end
    tick();
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    logic [2*W-1:0] p;
    int lat, pulse, bc;
    sa = '{4'h8, 4'hD, 4'h8, 4'h0};
    sb = '{4'h8, 4'h5, 4'h7, 4'hF};
    for (int i = 0; i < 4; i++) begin
      do_op(sa[i], sb[i], p, lat, pulse, bc);
      checks++;
      if (p !== model(sa[i], sb[i]) || lat !== W) begin
        errors++;
        $display("FAIL signed_product %h*%h: got %h after %0d edges, want %h after %0d",
                 sa[i], sb[i], p, lat, model(sa[i], sb[i]), W);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2*W-1:0] p;
    int lat, pulse, bc;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_op(a, b, p, lat, pulse, bc);
      checks++;
      if (p !== model(a, b) || lat !== W || pulse !== 1) begin
        errors++;
        $display("FAIL random_op %h*%h: got %h lat=%0d pulse=%0d, want %h lat=%0d pulse=1",
                 a, b, p, lat, pulse, model(a, b), W);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    test_reset();
    test_corners();
    test_start_during_busy();
    test_reset_mid_op();
    test_back_to_back();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
